tag_alloc_ctrl: RTL

- Allocation and return controller for the dispatcher's physical-tag free list.
- Grants one free tag per cycle to the dispatch stage, pulling it from the free-list FIFO.
- Collects returning tags from NUM_SRC completion/retire sources into per-source holding registers and round-robin arbitrates them onto the free list's single push port.
- Tracks the number of free tags and flags tag over-return (double free).

---
 rtl/tag_alloc_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/tag_alloc_ctrl.sv
// tag_alloc_ctrl: free-list tag allocator with round-robin arbitration of returned tags
module tag_alloc_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 6,
    parameter int SIZE    = 64,
    localparam int PW     = $clog2(NUM_SRC),
    localparam int CW     = $clog2(SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_req,
    output logic                     disp_gnt,
    output logic [TAG_W-1:0]         disp_tag,
    input  logic [NUM_SRC-1:0]       ret_valid,
    input  logic [NUM_SRC*TAG_W-1:0] ret_tag,
    output logic [NUM_SRC-1:0]       ret_ready,
    input  logic [TAG_W-1:0]         fl_tag_out,
    output logic                     fl_pull,
    output logic [TAG_W-1:0]         fl_tag_in,
    output logic                     fl_push,
    input  logic                     fl_full,
    input  logic                     fl_empty,
    output logic [CW-1:0]            free_cnt,
    output logic                     dbl_free_err
);
    logic [NUM_SRC-1:0] hold_v;
    logic [TAG_W-1:0]   hold_tag [NUM_SRC];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic               any_v;

    assign disp_gnt  = disp_req & ~fl_empty;
    assign disp_tag  = fl_tag_out;
    assign fl_pull   = disp_gnt;
    assign ret_ready = ~hold_v;
    assign fl_push   = any_v & ~fl_full;
    assign fl_tag_in = fl_push ? hold_tag[gnt_idx] : '0;

    // scan from the farthest offset down so the closest source to rr_ptr wins
    always_comb begin
        any_v   = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hold_v[rr_ptr + PW'(k)]) begin
                any_v   = 1'b1;
                gnt_idx = rr_ptr + PW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v       <= '0;
            for (int i = 0; i < NUM_SRC; i++) hold_tag[i] <= '0;
            rr_ptr       <= '0;
            free_cnt     <= CW'(SIZE);
            dbl_free_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fl_push && gnt_idx == PW'(i)) hold_v[i] <= 1'b0;
                else if (ret_valid[i] && !hold_v[i]) begin
                    hold_v[i]   <= 1'b1;
                    hold_tag[i] <= ret_tag[i*TAG_W +: TAG_W];
                end
            end
            if (fl_push) rr_ptr <= gnt_idx + 1'b1;
            if (fl_push && !fl_pull && free_cnt != CW'(SIZE)) free_cnt <= free_cnt + 1'b1;
            else if (fl_pull && !fl_push && free_cnt != '0) free_cnt <= free_cnt - 1'b1;
            if (|hold_v && free_cnt == CW'(SIZE)) dbl_free_err <= 1'b1;
        end
    end
endmodule
